// File: rtl/hex_coverage_rasterizer.sv
// Rounds a fixed-point axial coordinate to its hex, then streams the centre and rings 1..R, one hex per beat.
// Accept to first beat is 3 edges; a beat advances only on out_valid&&out_ready, and no request is taken while a walk is in flight.
module hex_coverage_rasterizer #(
    parameter int COORD_W    = 32,
    parameter int FRAC_BITS  = 16,
    parameter int RAD_W      = 4,
    parameter int MAX_RADIUS = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] q_f,
    input  logic [COORD_W-1:0] r_f,
    input  logic [RAD_W-1:0]   radius,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_q,
    output logic [COORD_W-1:0] out_r,
    output logic [RAD_W-1:0]   out_ring,
    output logic               out_last
);
    localparam int XW = COORD_W + 1;
    localparam logic signed [XW-1:0] HALF = XW'(1) <<< (FRAC_BITS - 1);
    localparam logic [RAD_W-1:0] RAD_MAX = RAD_W'(MAX_RADIUS);

    typedef enum logic [1:0] {IDLE, ROUND, CORRECT, EMIT} state_t;

    state_t                    state_q;
    logic                      in_ready_q;
    logic [COORD_W-1:0]        qf_q, rf_q;
    logic [RAD_W-1:0]          rad_q;
    logic signed [XW-1:0]      qi_q, ri_q, si_q;
    logic [XW-1:0]             dq_q, dr_q, ds_q;
    logic [COORD_W-1:0]        cen_q_q, cen_r_q;
    logic [RAD_W-1:0]          ring_q, step_q;
    logic [2:0]                side_q;
    logic                      out_valid_q, out_last_q;
    logic [COORD_W-1:0]        out_q_q, out_r_q;
    logic [RAD_W-1:0]          out_ring_q;

    function automatic logic signed [XW-1:0] round_fx(input logic signed [XW-1:0] x);
        return (x + HALF) >>> FRAC_BITS;
    endfunction

    function automatic logic [XW-1:0] err_fx(input logic signed [XW-1:0] x,
                                             input logic signed [XW-1:0] xi);
        logic signed [XW-1:0] diff;
        diff = (xi <<< FRAC_BITS) - x;
        return diff[XW-1] ? XW'(-diff) : XW'(diff);
    endfunction

    // Rounding datapath; only its registered result in ROUND matters.
    logic signed [XW-1:0] qx, rx, sx, qi_d, ri_d, si_d;
    always_comb begin
        qx   = {qf_q[COORD_W-1], qf_q};
        rx   = {rf_q[COORD_W-1], rf_q};
        sx   = -qx - rx;
        qi_d = round_fx(qx);
        ri_d = round_fx(rx);
        si_d = round_fx(sx);
    end

    logic [COORD_W-1:0] cq_d, cr_d;
    always_comb begin
        if (dq_q > dr_q && dq_q > ds_q) begin
            cq_d = COORD_W'(-ri_q - si_q);
            cr_d = COORD_W'(ri_q);
        end else if (dr_q > ds_q) begin
            cq_d = COORD_W'(qi_q);
            cr_d = COORD_W'(-qi_q - si_q);
        end else begin
            cq_d = COORD_W'(qi_q);
            cr_d = COORD_W'(ri_q);
        end
    end

    // Next beat of the ring walk, used on each accepted beat.
    logic [COORD_W-1:0] dir_q, dir_r, kx, beat_q_d, beat_r_d;
    logic [RAD_W-1:0]   ring_d, step_d;
    logic [2:0]         side_d;
    logic               last_d, step_wrap;
    always_comb begin
        case (side_q)
            3'd0:    begin dir_q = COORD_W'(1);  dir_r = '0;           end
            3'd1:    begin dir_q = COORD_W'(1);  dir_r = '1;           end
            3'd2:    begin dir_q = '0;           dir_r = '1;           end
            3'd3:    begin dir_q = '1;           dir_r = '0;           end
            3'd4:    begin dir_q = '1;           dir_r = COORD_W'(1);  end
            default: begin dir_q = '0;           dir_r = COORD_W'(1);  end
        endcase
        kx        = COORD_W'(ring_q) + COORD_W'(1);
        step_wrap = (step_q == ring_q - RAD_W'(1));
        beat_q_d  = out_q_q + dir_q;
        beat_r_d  = out_r_q + dir_r;
        ring_d    = ring_q;
        step_d    = step_q + RAD_W'(1);
        side_d    = side_q;
        last_d    = 1'b0;
        if (ring_q == '0 || (step_wrap && side_q == 3'd5)) begin
            ring_d   = ring_q + RAD_W'(1);
            step_d   = '0;
            side_d   = 3'd0;
            beat_q_d = cen_q_q - kx;
            beat_r_d = cen_r_q + kx;
        end else begin
            if (step_wrap) begin
                step_d = '0;
                side_d = side_q + 3'd1;
            end
            last_d = (ring_q == rad_q) && (side_d == 3'd5) && (step_d == ring_q - RAD_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            qf_q        <= '0;
            rf_q        <= '0;
            rad_q       <= '0;
            qi_q        <= '0;
            ri_q        <= '0;
            si_q        <= '0;
            dq_q        <= '0;
            dr_q        <= '0;
            ds_q        <= '0;
            cen_q_q     <= '0;
            cen_r_q     <= '0;
            ring_q      <= '0;
            step_q      <= '0;
            side_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_ring_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        qf_q       <= q_f;
                        rf_q       <= r_f;
                        rad_q      <= (radius > RAD_MAX) ? RAD_MAX : radius;
                        in_ready_q <= 1'b0;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    qi_q    <= qi_d;
                    ri_q    <= ri_d;
                    si_q    <= si_d;
                    dq_q    <= err_fx(qx, qi_d);
                    dr_q    <= err_fx(rx, ri_d);
                    ds_q    <= err_fx(sx, si_d);
                    state_q <= CORRECT;
                end
                CORRECT: begin
                    cen_q_q     <= cq_d;
                    cen_r_q     <= cr_d;
                    out_q_q     <= cq_d;
                    out_r_q     <= cr_d;
                    out_ring_q  <= '0;
                    out_last_q  <= (rad_q == '0);
                    out_valid_q <= 1'b1;
                    ring_q      <= '0;
                    step_q      <= '0;
                    side_q      <= '0;
                    state_q     <= EMIT;
                end
                default: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            out_q_q    <= beat_q_d;
                            out_r_q    <= beat_r_d;
                            out_ring_q <= ring_d;
                            out_last_q <= last_d;
                            ring_q     <= ring_d;
                            step_q     <= step_d;
                            side_q     <= side_d;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign out_ring  = out_ring_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_hex_coverage_rasterizer.sv
// Bench for hex_coverage_rasterizer: fixed vectors, random requests against a real-arithmetic model, reset corners.
module tb_hex_coverage_rasterizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] q_f, r_f, out_q, out_r;
    logic [3:0]  radius, out_ring;

    hex_coverage_rasterizer #(.COORD_W(32), .FRAC_BITS(16), .RAD_W(4), .MAX_RADIUS(7)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .q_f(q_f), .r_f(r_f), .radius(radius), .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_ring(out_ring), .out_last(out_last));

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int eq[$];
    int er[$];
    int ering[$];
    int dirq[6] = '{1, 1, 0, -1, -1, 0};
    int dirr[6] = '{0, -1, -1, 0, 1, 1};

    typedef struct {
        logic [31:0] qf;
        logic [31:0] rf;
        logic [3:0]  rad;
        int          cq;
        int          cr;
        int          n;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic real fabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Reference: exact real rounding, then the hex walk as centre plus rings.
    function automatic void build_model(input logic [31:0] qf, input logic [31:0] rf, input int rad);
        real q, r, s, dq, dr, ds;
        int  qi, ri, si, cq, cr, rr, cur_q, cur_r;
        q  = $itor($signed(qf)) / 65536.0;
        r  = $itor($signed(rf)) / 65536.0;
        s  = -q - r;
        qi = $rtoi($floor(q + 0.5));
        ri = $rtoi($floor(r + 0.5));
        si = $rtoi($floor(s + 0.5));
        dq = fabs(qi - q);
        dr = fabs(ri - r);
        ds = fabs(si - s);
        if (dq > dr && dq > ds) begin cq = -ri - si; cr = ri; end
        else if (dr > ds)       begin cq = qi; cr = -qi - si; end
        else                    begin cq = qi; cr = ri; end
        rr = (rad > 7) ? 7 : rad;
        eq.delete(); er.delete(); ering.delete();
        eq.push_back(cq); er.push_back(cr); ering.push_back(0);
        for (int k = 1; k <= rr; k++) begin
            cur_q = cq - k;
            cur_r = cr + k;
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < k; j++) begin
                    eq.push_back(cur_q); er.push_back(cur_r); ering.push_back(k);
                    cur_q += dirq[i];
                    cur_r += dirr[i];
                end
            end
        end
    endfunction

    task automatic send(input logic [31:0] qf, input logic [31:0] rf, input logic [3:0] rad, input bit keep);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1; q_f = qf; r_f = rf; radius = rad;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic collect(input int ready_pct, output int nbeats, output int fq, output int fr);
        int cyc = 0, lat = 0, ready_hi = 0;
        bit seen = 0, stalled = 0, done = 0;
        logic [31:0] hq, hr;
        logic [3:0]  hring;
        logic        hlast;
        nbeats = 0; fq = 0; fr = 0;
        hq = '0; hr = '0; hring = '0; hlast = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            #1; cyc++;
            if (!seen) begin
                lat++;
                if (out_valid) begin
                    seen = 1;
                    chk("first_valid_latency", lat, 3);
                    fq = $signed(out_q); fr = $signed(out_r);
                end
            end
            if (in_ready) ready_hi++;
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_q", out_q, hq);
                chk("stall_r", out_r, hr);
                chk("stall_ring", out_ring, hring);
                chk("stall_last", out_last, hlast);
            end
            stalled = out_valid && !out_ready;
            hq = out_q; hr = out_r; hring = out_ring; hlast = out_last;
            if (out_valid && out_ready) begin
                if (nbeats < eq.size()) begin
                    chk("beat_q", $signed(out_q), eq[nbeats]);
                    chk("beat_r", $signed(out_r), er[nbeats]);
                    chk("beat_ring", out_ring, ering[nbeats]);
                    chk("beat_last", out_last, (nbeats == eq.size() - 1));
                end else begin
                    chk("extra_beat", nbeats, eq.size() - 1);
                end
                nbeats++;
                if (out_last) done = 1;
            end
        end
        chk("collect_done", done, 1);
        chk("in_ready_low_during_request", ready_hi, 0);
        chk("beat_count", nbeats, eq.size());
        @(negedge clk); #1;
        chk("in_ready_after_last", in_ready, 1);
    endtask

    initial begin
        int n, fq, fr, cnt, w;
        logic [31:0] rq, rr;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        q_f = '0; r_f = '0; radius = '0;

        vt[0] = '{32'h0000_6666, 32'h0000_6666, 4'd0, 0, 1, 1};
        vt[1] = '{32'h0000_0000, 32'h0000_0000, 4'd1, 0, 0, 7};
        vt[2] = '{32'h0002_8000, 32'hFFFF_0000, 4'd2, 3, -1, 19};
        vt[3] = '{32'hFFFF_8000, 32'h0000_0000, 4'd0, 0, 0, 1};
        vt[4] = '{32'h0000_999A, 32'h0000_999A, 4'd1, 1, 0, 7};
        vt[5] = '{32'h0000_8000, 32'h0000_4CCD, 4'd3, 1, 0, 37};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_q", out_q, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_out_ring", out_ring, 0);
        chk("reset_out_last", out_last, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("in_ready_after_release", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            build_model(vt[i].qf, vt[i].rf, int'(vt[i].rad));
            send(vt[i].qf, vt[i].rf, vt[i].rad, 1'b0);
            collect((i < 2) ? 100 : 50, n, fq, fr);
            chk("vec_centre_q", fq, vt[i].cq);
            chk("vec_centre_r", fr, vt[i].cr);
            chk("vec_beats", n, vt[i].n);
        end

        // Clamped radius with in_valid held high across the whole walk.
        build_model(32'h0000_0000, 32'h0000_0000, 15);
        send(32'h0000_0000, 32'h0000_0000, 4'd15, 1'b1);
        q_f = 32'h0003_0000; r_f = 32'h0001_0000; radius = 4'd0;
        collect(100, n, fq, fr);
        chk("clamp_beats", n, 169);
        @(posedge clk); #1;
        in_valid = 1'b0;
        build_model(32'h0003_0000, 32'h0001_0000, 0);
        collect(100, n, fq, fr);
        chk("held_second_q", fq, 3);
        chk("held_second_beats", n, 1);

        for (int t = 0; t < 25; t++) begin
            rq = $urandom_range(0, 32'h0FFF_FFFF) - 32'h0800_0000;
            rr = $urandom_range(0, 32'h0FFF_FFFF) - 32'h0800_0000;
            if (t % 4 == 1) rq[15:0] = 16'h8000;
            if (t % 4 == 2) rr[15:0] = 16'h8000;
            build_model(rq, rr, int'($urandom_range(0, 9)));
            send(rq, rr, 4'($urandom_range(0, 9) > 0 ? ering[ering.size() - 1] : 0), 1'b0);
            build_model(rq, rr, int'(radius));
            collect(65, n, fq, fr);
        end

        // Reset while the fourth beat of a radius-2 walk is presented.
        build_model(32'h0000_0000, 32'h0000_0000, 2);
        send(32'h0000_0000, 32'h0000_0000, 4'd2, 1'b0);
        cnt = 0; w = 0;
        while (w < 100) begin
            @(negedge clk); out_ready = 1'b1; #1; w++;
            if (out_valid && cnt == 3) break;
            if (out_valid) cnt++;
        end
        chk("abort_reached_beat4", cnt, 3);
        reset = 1'b1; #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_out_ring", out_ring, 0);
        chk("abort_out_q", out_q, 0);
        @(negedge clk); #1;
        chk("abort_hold_valid", out_valid, 0);
        reset = 1'b0;
        build_model(32'h0002_0000, 32'hFFFE_0000, 0);
        send(32'h0002_0000, 32'hFFFE_0000, 4'd0, 1'b0);
        collect(100, n, fq, fr);
        chk("after_abort_beats", n, 1);
        chk("after_abort_r", fr, -2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
